// File: rtl/mbist_scan_host.sv
// mbist_scan_host: host-side master for the MBIST serial control pins.
// Turns one-word commands into RUN/SHIFT/LOAD/DISABLE pin sequences.
module mbist_scan_host #(
  parameter int CHAIN_WD = 32,
  parameter int LEN_WD   = 6,
  parameter int TMO_WD   = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [LEN_WD-1:0]   cmd_len,
  input  logic [CHAIN_WD-1:0] cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [CHAIN_WD-1:0] rsp_rdata,
  output logic [1:0]          rsp_status,
  input  logic [TMO_WD-1:0]   cfg_timeout,
  output logic                bist_en,
  output logic                bist_run,
  output logic                bist_shift,
  output logic                bist_load,
  output logic                bist_sdi,
  input  logic                bist_sdo,
  input  logic                bist_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_SHIFT, S_LOAD, S_RESP
  } state_t;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_SHIFT = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_TMO    = 2'b01;
  localparam logic [1:0] ST_BADLEN = 2'b10;

  state_t              state_q, state_d;
  logic [LEN_WD-1:0]   len_q, len_d;
  logic [LEN_WD-1:0]   idx_q, idx_d;
  logic [CHAIN_WD-1:0] wdata_q, wdata_d;
  logic [CHAIN_WD-1:0] rdata_q, rdata_d;
  logic [TMO_WD-1:0]   tmo_q, tmo_d;
  logic [TMO_WD-1:0]   cnt_q, cnt_d;
  logic                first_q, first_d;
  logic [1:0]          status_q, status_d;
  logic                en_q, en_d;

  // State and datapath registers, synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      status_q <= ST_OK;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      status_q <= status_d;
      en_q     <= en_d;
    end
  end

  // Command decode, op sequencing and response capture
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    status_d = status_q;
    en_d     = en_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          len_d    = cmd_len;
          wdata_d  = cmd_wdata;
          tmo_d    = cfg_timeout;
          idx_d    = '0;
          cnt_d    = '0;
          first_d  = 1'b1;
          rdata_d  = '0;
          status_d = ST_OK;
          en_d     = 1'b1;
          unique case (cmd_op)
            OP_RUN:  state_d = S_RUN;
            OP_SHIFT: begin
              if (cmd_len > LEN_WD'(CHAIN_WD)) begin
                status_d = ST_BADLEN;
                state_d  = S_RESP;
              end else if (cmd_len == '0) begin
                state_d = S_RESP;
              end else begin
                state_d = S_SHIFT;
              end
            end
            OP_LOAD: state_d = S_LOAD;
            default: begin
              en_d    = 1'b0;
              state_d = S_RESP;
            end
          endcase
        end
      end
      S_RUN: begin
        cnt_d   = cnt_q + TMO_WD'(1);
        first_d = 1'b0;
        if (!first_q && bist_done) begin
          state_d = S_RESP;
        end else if (tmo_q != '0 &&
                     cnt_q == tmo_q - TMO_WD'(1)) begin
          status_d = ST_TMO;
          state_d  = S_RESP;
        end
      end
      S_SHIFT: begin
        wdata_d = wdata_q >> 1;
        idx_d   = idx_q + LEN_WD'(1);
        for (int i = 0; i < CHAIN_WD; i++) begin
          if (idx_q == LEN_WD'(i)) rdata_d[i] = bist_sdo;
        end
        if (idx_q == len_q - LEN_WD'(1)) state_d = S_RESP;
      end
      S_LOAD: state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_status = status_q;
  assign bist_en    = en_q;
  assign bist_run   = (state_q == S_RUN);
  assign bist_shift = (state_q == S_SHIFT);
  assign bist_load  = (state_q == S_LOAD);
  assign bist_sdi   = (state_q == S_SHIFT) & wdata_q[0];

endmodule

// File: tb/tb_mbist_scan_host.sv
// tb_mbist_scan_host: randomized command bench with a chain/done model.
// Expectations come from op rules, not from the design's state machine.
module tb_mbist_scan_host;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [15:0] cfg_timeout = '0;
  logic        bist_en, bist_run, bist_shift, bist_load, bist_sdi;
  logic        bist_sdo = 1'b0;
  logic        bist_done = 1'b0;

  mbist_scan_host dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
    .cfg_timeout(cfg_timeout),
    .bist_en(bist_en), .bist_run(bist_run),
    .bist_shift(bist_shift), .bist_load(bist_load),
    .bist_sdi(bist_sdi), .bist_sdo(bist_sdo),
    .bist_done(bist_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus side: written only by the initial block
  int          gen = 0;
  int          done_at = 0;
  logic [7:0]  ch_bits = '0;
  int          ch_dly = 1;

  // Monitor side: written only by the monitor
  int          runs = 0, shifts = 0, loads = 0, viol = 0;
  logic [31:0] sdi_v = '0;
  bit          chain[$];
  int          last_gen = 0;

  // Chain model (sdo = sdi delayed ch_dly), done driver, pin rules
  always @(negedge clk) begin
    if (gen != last_gen) begin
      last_gen = gen;
      runs = 0; shifts = 0; loads = 0; sdi_v = '0;
      chain.delete();
      for (int i = 0; i < ch_dly; i++) chain.push_back(ch_bits[i]);
    end
    if (bist_run) begin
      bist_done = (done_at > 0) && (runs >= done_at - 1);
      runs++;
    end else begin
      bist_done = 1'b0;
    end
    if (bist_shift) begin
      if (shifts < 32) sdi_v[shifts] = bist_sdi;
      bist_sdo = chain.pop_front();
      chain.push_back(bist_sdi);
      shifts++;
    end else begin
      bist_sdo = 1'b0;
    end
    if (bist_load) loads++;
    if (int'(bist_run) + int'(bist_shift) + int'(bist_load) > 1)
      viol++;
    if ((cmd_ready || rsp_valid) &&
        (bist_run || bist_shift || bist_load)) viol++;
    if (!bist_shift && bist_sdi) viol++;
    if (cmd_ready && rsp_valid) viol++;
  end

  logic en_m = 1'b0;

  task automatic exec(input logic [1:0] op, input int len,
                      input logic [31:0] wd, input int tmo,
                      input int dat);
    logic [31:0] exp_rd, mask;
    logic [1:0]  exp_st;
    int          exp_r, exp_s, exp_l, n;
    ch_dly  = int'($urandom_range(1, 8));
    ch_bits = 8'($urandom);
    done_at = dat;
    gen++;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_len     = len[5:0];
    cmd_wdata   = wd;
    cfg_timeout = tmo[15:0];
    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd_wdata   = $urandom;
    cfg_timeout = 16'($urandom);
    exp_rd = '0; exp_st = 2'b00; mask = '0;
    exp_r = 0; exp_s = 0; exp_l = 0;
    case (op)
      2'd0: begin
        if (tmo == 0) exp_r = dat;
        else if (dat == 0 || dat > tmo) exp_r = tmo;
        else exp_r = dat;
        if (tmo != 0 && (dat == 0 || dat > tmo)) exp_st = 2'b01;
      end
      2'd1: begin
        if (len > 32) exp_st = 2'b10;
        else begin
          exp_s = len;
          for (int i = 0; i < len; i++) begin
            mask[i]   = 1'b1;
            exp_rd[i] = (i < ch_dly) ? ch_bits[i] : wd[i - ch_dly];
          end
        end
      end
      2'd2: exp_l = 1;
      default: ;
    endcase
    en_m = (op != 2'd3);
    n = 0;
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rdata_early", rsp_rdata, exp_rd);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rsp_ready = 1'b1;
    chk("rsp_hold", 32'(rsp_valid), 32'd1);
    chk("rdata", rsp_rdata, exp_rd);
    chk("status", 32'(rsp_status), 32'(exp_st));
    chk("bist_en", 32'(bist_en), 32'(en_m));
    chk("run_cycles", runs, exp_r);
    chk("shift_cycles", shifts, exp_s);
    chk("load_cycles", loads, exp_l);
    if (op == 2'd1) chk("sdi_bits", sdi_v, wd & mask);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n, op, tmo, dat, len;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_pins", {27'd0, bist_en, bist_run, bist_shift,
                     bist_load, bist_sdi}, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_status", 32'(rsp_status), 32'd0);
    wb_rst_i = 1'b0;

    exec(2'd1, 8, 32'hA5, 0, 0);
    exec(2'd0, 0, 0, 0, 100);
    exec(2'd0, 0, 0, 20, 0);
    exec(2'd0, 0, 0, 20, 20);
    exec(2'd0, 0, 0, 1, 0);
    exec(2'd1, 40, 32'hFFFF_FFFF, 0, 0);
    exec(2'd1, 33, 32'h1234_5678, 0, 0);
    exec(2'd1, 0, 32'hDEAD_BEEF, 0, 0);
    exec(2'd1, 32, 32'h8000_0001, 0, 0);
    exec(2'd2, 0, 0, 0, 0);
    exec(2'd3, 0, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 3));
      len = int'($urandom_range(0, 40));
      tmo = int'($urandom_range(0, 30));
      dat = int'($urandom_range(2, 40));
      if (tmo != 0 && $urandom_range(0, 1) == 1) dat = 0;
      exec(op[1:0], len, $urandom, tmo, dat);
    end

    ch_dly = 4; ch_bits = 8'h0F; done_at = 0; gen++;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_len = 6'd16;
    cmd_wdata = $urandom;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (shifts < 5 && n < 50) begin @(negedge clk); n++; end
    chk("mid_in_shift", 32'(bist_shift), 32'd1);
    wb_rst_i = 1'b1;
    @(negedge clk);
    chk("mid_pins", {27'd0, bist_en, bist_run, bist_shift,
                     bist_load, bist_sdi}, 32'd0);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rsp", 32'(rsp_valid), 32'd0);
    chk("mid_rdata", rsp_rdata, 32'd0);
    wb_rst_i = 1'b0;
    en_m = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
    exec(2'd2, 0, 0, 0, 0);

    chk("pin_rules", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
